// File: rtl/rop_req_serializer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rop_req_serializer
//   Responder end of the ROP request interface. Accepts one warp-wide request
//   (uuid, lane mask, per-lane position/color/depth/face) and emits one
//   fragment per active lane, lowest lane index first, one per handshake.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready combinational from
//                         frag_ready, never from req_valid)
//   req_uuid, req_mask    instruction uuid, active-lane mask
//   req_pos_x/_y, req_color, req_depth, req_face
//                         per-lane data, lane i at [i*W +: W]
//   frag_valid/frag_ready fragment handshake
//   frag_uuid, frag_lane, frag_pos_x/_y, frag_color, frag_depth, frag_face
//                         registered fragment payload
//   frag_last             last fragment of its request
//   busy                  request captured, fragments pending
// ---------------------------------------------------------------------------
module rop_req_serializer #(
   parameter int NUM_LANES  = 4,
   parameter int DIM_BITS   = 11,
   parameter int DEPTH_BITS = 24,
   parameter int UUID_WIDTH = 1,
   parameter int LANE_BITS  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [UUID_WIDTH-1:0]            req_uuid,
   input  logic [NUM_LANES-1:0]             req_mask,
   input  logic [NUM_LANES*DIM_BITS-1:0]    req_pos_x,
   input  logic [NUM_LANES*DIM_BITS-1:0]    req_pos_y,
   input  logic [NUM_LANES*32-1:0]          req_color,
   input  logic [NUM_LANES*DEPTH_BITS-1:0]  req_depth,
   input  logic [NUM_LANES-1:0]             req_face,
   output logic                             frag_valid,
   input  logic                             frag_ready,
   output logic [UUID_WIDTH-1:0]            frag_uuid,
   output logic [LANE_BITS-1:0]             frag_lane,
   output logic [DIM_BITS-1:0]              frag_pos_x,
   output logic [DIM_BITS-1:0]              frag_pos_y,
   output logic [31:0]                      frag_color,
   output logic [DEPTH_BITS-1:0]            frag_depth,
   output logic                             frag_face,
   output logic                             frag_last,
   output logic                             busy
);

   typedef enum logic {ST_IDLE = 1'b0, ST_DRAIN = 1'b1} state_t;

   state_t                          r_state;
   logic [NUM_LANES-1:0]            r_pending;
   logic [UUID_WIDTH-1:0]           r_uuid;
   logic [NUM_LANES*DIM_BITS-1:0]   r_pos_x;
   logic [NUM_LANES*DIM_BITS-1:0]   r_pos_y;
   logic [NUM_LANES*32-1:0]         r_color;
   logic [NUM_LANES*DEPTH_BITS-1:0] r_depth;
   logic [NUM_LANES-1:0]            r_face;

   logic                            r_frag_valid;
   logic                            r_frag_last;
   logic [UUID_WIDTH-1:0]           r_frag_uuid;
   logic [LANE_BITS-1:0]            r_frag_lane;
   logic [DIM_BITS-1:0]             r_frag_pos_x;
   logic [DIM_BITS-1:0]             r_frag_pos_y;
   logic [31:0]                     r_frag_color;
   logic [DEPTH_BITS-1:0]           r_frag_depth;
   logic                            r_frag_face;

   logic                            w_fire;
   logic                            w_accept;
   logic [NUM_LANES-1:0]            w_lane_onehot;
   logic [NUM_LANES-1:0]            w_pend_after;
   logic [NUM_LANES-1:0]            w_pend_next;
   logic                            w_pend_any;
   logic                            w_next_last;
   logic [LANE_BITS-1:0]            w_next_lane;

   // Data source for the next fragment: a request accepted this cycle
   // supplies its own lanes directly so the first fragment has 1-cycle latency.
   logic [UUID_WIDTH-1:0]           w_src_uuid;
   logic [NUM_LANES*DIM_BITS-1:0]   w_src_pos_x;
   logic [NUM_LANES*DIM_BITS-1:0]   w_src_pos_y;
   logic [NUM_LANES*32-1:0]         w_src_color;
   logic [NUM_LANES*DEPTH_BITS-1:0] w_src_depth;
   logic [NUM_LANES-1:0]            w_src_face;

   logic [DIM_BITS-1:0]             w_x_arr     [NUM_LANES];
   logic [DIM_BITS-1:0]             w_y_arr     [NUM_LANES];
   logic [31:0]                     w_color_arr [NUM_LANES];
   logic [DEPTH_BITS-1:0]           w_depth_arr [NUM_LANES];

   assign w_fire   = r_frag_valid && frag_ready;
   // A new request may enter while the final fragment of the current one
   // leaves, which keeps back-to-back requests bubble-free.
   assign req_ready = (r_state == ST_IDLE) || (w_fire && r_frag_last);
   assign w_accept  = req_valid && req_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         assign w_lane_onehot[gi] = (r_frag_lane == LANE_BITS'(gi));
         assign w_x_arr[gi]       = w_src_pos_x[gi*DIM_BITS +: DIM_BITS];
         assign w_y_arr[gi]       = w_src_pos_y[gi*DIM_BITS +: DIM_BITS];
         assign w_color_arr[gi]   = w_src_color[gi*32 +: 32];
         assign w_depth_arr[gi]   = w_src_depth[gi*DEPTH_BITS +: DEPTH_BITS];
      end
   endgenerate

   assign w_pend_after = w_fire ? (r_pending & ~w_lane_onehot) : r_pending;
   // Accept only happens when w_pend_after is empty, so overwriting is safe.
   assign w_pend_next  = w_accept ? req_mask : w_pend_after;
   assign w_pend_any   = (w_pend_next != '0);
   // Exactly one bit set: clearing the lowest set bit leaves nothing.
   assign w_next_last  = w_pend_any &&
                         ((w_pend_next & (w_pend_next - NUM_LANES'(1))) == '0);

   assign w_src_uuid  = w_accept ? req_uuid  : r_uuid;
   assign w_src_pos_x = w_accept ? req_pos_x : r_pos_x;
   assign w_src_pos_y = w_accept ? req_pos_y : r_pos_y;
   assign w_src_color = w_accept ? req_color : r_color;
   assign w_src_depth = w_accept ? req_depth : r_depth;
   assign w_src_face  = w_accept ? req_face  : r_face;

   // Lowest pending lane wins; scanning downward lets the lowest overwrite.
   always_comb begin
      w_next_lane = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (w_pend_next[i]) begin
            w_next_lane = LANE_BITS'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_pending    <= '0;
         r_uuid       <= '0;
         r_pos_x      <= '0;
         r_pos_y      <= '0;
         r_color      <= '0;
         r_depth      <= '0;
         r_face       <= '0;
         r_frag_valid <= 1'b0;
         r_frag_last  <= 1'b0;
         r_frag_uuid  <= '0;
         r_frag_lane  <= '0;
         r_frag_pos_x <= '0;
         r_frag_pos_y <= '0;
         r_frag_color <= '0;
         r_frag_depth <= '0;
         r_frag_face  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_uuid  <= req_uuid;
            r_pos_x <= req_pos_x;
            r_pos_y <= req_pos_y;
            r_color <= req_color;
            r_depth <= req_depth;
            r_face  <= req_face;
         end
         r_pending    <= w_pend_next;
         r_state      <= w_pend_any ? ST_DRAIN : ST_IDLE;
         r_frag_valid <= w_pend_any;
         r_frag_last  <= w_next_last;
         // Under back-pressure w_pend_next equals r_pending and no request is
         // accepted, so the reload below reproduces the held payload.
         if (w_pend_any) begin
            r_frag_uuid  <= w_src_uuid;
            r_frag_lane  <= w_next_lane;
            r_frag_pos_x <= w_x_arr[w_next_lane];
            r_frag_pos_y <= w_y_arr[w_next_lane];
            r_frag_color <= w_color_arr[w_next_lane];
            r_frag_depth <= w_depth_arr[w_next_lane];
            r_frag_face  <= w_src_face[w_next_lane];
         end
      end
   end

   assign frag_valid = r_frag_valid;
   assign frag_last  = r_frag_last;
   assign frag_uuid  = r_frag_uuid;
   assign frag_lane  = r_frag_lane;
   assign frag_pos_x = r_frag_pos_x;
   assign frag_pos_y = r_frag_pos_y;
   assign frag_color = r_frag_color;
   assign frag_depth = r_frag_depth;
   assign frag_face  = r_frag_face;
   assign busy       = (r_state == ST_DRAIN);

endmodule

// File: tb/tb_rop_req_serializer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_rop_req_serializer
//   Directed scenarios followed by a randomized run. A queue of expected
//   fragments (each accepted request expanded lane by lane) is compared every
//   cycle against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_rop_req_serializer;

   localparam int NL   = 4;
   localparam int DB   = 11;
   localparam int ZB   = 24;
   localparam int UW   = 4;
   localparam int LB   = 2;
   localparam int NREQ = 8000;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [UW-1:0]    req_uuid = '0;
   logic [NL-1:0]    req_mask = '0;
   logic [NL*DB-1:0] req_pos_x = '0;
   logic [NL*DB-1:0] req_pos_y = '0;
   logic [NL*32-1:0] req_color = '0;
   logic [NL*ZB-1:0] req_depth = '0;
   logic [NL-1:0]    req_face = '0;
   logic             frag_valid;
   logic             frag_ready = 1'b1;
   logic [UW-1:0]    frag_uuid;
   logic [LB-1:0]    frag_lane;
   logic [DB-1:0]    frag_pos_x;
   logic [DB-1:0]    frag_pos_y;
   logic [31:0]      frag_color;
   logic [ZB-1:0]    frag_depth;
   logic             frag_face;
   logic             frag_last;
   logic             busy;

   always #5 clk = ~clk;

   rop_req_serializer #(
      .NUM_LANES (NL),
      .DIM_BITS  (DB),
      .DEPTH_BITS(ZB),
      .UUID_WIDTH(UW),
      .LANE_BITS (LB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_uuid  (req_uuid),
      .req_mask  (req_mask),
      .req_pos_x (req_pos_x),
      .req_pos_y (req_pos_y),
      .req_color (req_color),
      .req_depth (req_depth),
      .req_face  (req_face),
      .frag_valid(frag_valid),
      .frag_ready(frag_ready),
      .frag_uuid (frag_uuid),
      .frag_lane (frag_lane),
      .frag_pos_x(frag_pos_x),
      .frag_pos_y(frag_pos_y),
      .frag_color(frag_color),
      .frag_depth(frag_depth),
      .frag_face (frag_face),
      .frag_last (frag_last),
      .busy      (busy)
   );

   typedef struct {
      logic [UW-1:0] uuid;
      logic [LB-1:0] lane;
      logic [DB-1:0] x;
      logic [DB-1:0] y;
      logic [31:0]   color;
      logic [ZB-1:0] depth;
      logic          face;
      logic          last;
   } frag_t;

   frag_t q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    n_acc   = 0;
   bit    mon_en  = 1'b0;
   logic  exp_v;
   logic  exp_rdy;

   task automatic check_val(input string tag, input logic [127:0] obs,
                            input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data();
      req_uuid = UW'($urandom);
      for (int i = 0; i < NL; i++) begin
         req_pos_x[i*DB +: DB] = DB'($urandom);
         req_pos_y[i*DB +: DB] = DB'($urandom);
         req_color[i*32 +: 32] = $urandom;
         req_depth[i*ZB +: ZB] = ZB'($urandom);
      end
      req_face = NL'($urandom);
   endtask

   // Expand the request currently on the bus into its fragments.
   function automatic void push_req();
      frag_t f;
      for (int i = 0; i < NL; i++) begin
         if (req_mask[i]) begin
            f.uuid  = req_uuid;
            f.lane  = LB'(i);
            f.x     = req_pos_x[i*DB +: DB];
            f.y     = req_pos_y[i*DB +: DB];
            f.color = req_color[i*32 +: 32];
            f.depth = req_depth[i*ZB +: ZB];
            f.face  = req_face[i];
            f.last  = ((req_mask >> (i + 1)) == '0);
            q.push_back(f);
         end
      end
   endfunction

   // Per-cycle scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         exp_v = (q.size() != 0);
         check_val("frag_valid", frag_valid, exp_v);
         check_val("busy", busy, exp_v);
         exp_rdy = 1'b1;
         if (exp_v) begin
            exp_rdy = frag_ready && q[0].last;
            check_val("frag_data",
               {frag_uuid, frag_lane, frag_pos_x, frag_pos_y, frag_color,
                frag_depth, frag_face, frag_last},
               {q[0].uuid, q[0].lane, q[0].x, q[0].y, q[0].color,
                q[0].depth, q[0].face, q[0].last});
         end
         check_val("req_ready", req_ready, exp_rdy);
         if (exp_v && frag_ready) begin
            void'(q.pop_front());
         end
         if (req_valid && exp_rdy) begin
            n_acc++;
            push_req();
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc2;
      int cyc;
      int target;

      // Reset
      rand_data();
      req_mask   = '0;
      frag_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      step();
      mon_en = 1'b1;
      @(negedge clk);
      check_val("rst_state", {frag_valid, busy, frag_last, frag_lane, frag_pos_x, frag_color},
                {1'b0, 1'b0, 1'b0, 2'd0, 11'd0, 32'd0});
      check_val("rst_req_ready", req_ready, 1'b1);
      step();

      // 1: sparse mask 1011
      rand_data();
      req_mask  = 4'b1011;
      req_pos_x = {11'd40, 11'd30, 11'd20, 11'd10};
      req_valid = 1'b1;
      @(negedge clk);
      check_val("t1_accept", req_ready, 1'b1);
      step();
      req_valid = 1'b0;
      @(negedge clk);
      check_val("t1_frag0", {frag_valid, frag_lane, frag_pos_x, frag_last},
                {1'b1, 2'd0, 11'd10, 1'b0});
      step();
      @(negedge clk);
      check_val("t1_frag1", {frag_valid, frag_lane, frag_pos_x, frag_last},
                {1'b1, 2'd1, 11'd20, 1'b0});
      check_val("t1_rdy_mid", req_ready, 1'b0);
      step();
      @(negedge clk);
      check_val("t1_frag3", {frag_valid, frag_lane, frag_pos_x, frag_last},
                {1'b1, 2'd3, 11'd40, 1'b1});
      check_val("t1_rdy_last", req_ready, 1'b1);
      step();
      @(negedge clk);
      check_val("t1_idle", frag_valid, 1'b0);
      step();

      // 2: back-to-back full masks, no bubble
      acc2 = 0;
      rand_data();
      req_mask  = 4'hF;
      req_valid = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         if (k > 0) begin
            check_val("t2_valid", frag_valid, 1'b1);
            check_val("t2_last", frag_last, (k == 4 || k == 8));
         end
         if (req_valid && req_ready) acc2++;
         step();
         if (acc2 == 2) req_valid = 1'b0;
         else rand_data();
      end
      check_val("t2_accepts", acc2, 2);
      @(negedge clk);
      check_val("t2_idle", frag_valid, 1'b0);
      step();

      // 3: empty mask consumed silently, then single-lane request
      rand_data();
      req_uuid  = 4'd7;
      req_mask  = 4'b0000;
      req_valid = 1'b1;
      @(negedge clk);
      check_val("t3_accept0", req_ready, 1'b1);
      step();
      rand_data();
      req_mask = 4'b0100;
      @(negedge clk);
      check_val("t3_novalid", {frag_valid, busy, req_ready}, {1'b0, 1'b0, 1'b1});
      step();
      req_valid = 1'b0;
      @(negedge clk);
      check_val("t3_frag2", {frag_valid, frag_lane, frag_last}, {1'b1, 2'd2, 1'b1});
      step();
      @(negedge clk);
      check_val("t3_idle", frag_valid, 1'b0);
      step();

      // 4: back-pressure holds lane 1
      rand_data();
      req_pos_x[DB +: DB] = 11'd123;
      req_mask   = 4'b0110;
      req_valid  = 1'b1;
      frag_ready = 1'b0;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("t4_hold", {frag_valid, frag_lane, frag_pos_x, frag_last},
                   {1'b1, 2'd1, 11'd123, 1'b0});
         check_val("t4_rdy_stall", req_ready, 1'b0);
         step();
      end
      frag_ready = 1'b1;
      @(negedge clk);
      check_val("t4_release", {frag_valid, frag_lane, frag_pos_x, frag_last},
                {1'b1, 2'd1, 11'd123, 1'b0});
      check_val("t4_rdy_rel", req_ready, 1'b0);
      step();
      @(negedge clk);
      check_val("t4_frag2", {frag_valid, frag_lane, frag_last}, {1'b1, 2'd2, 1'b1});
      check_val("t4_rdy_last", req_ready, 1'b1);
      step();
      @(negedge clk);
      check_val("t4_idle", frag_valid, 1'b0);
      step();

      // 5: asynchronous reset mid-drain
      rand_data();
      req_mask  = 4'hF;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      @(negedge clk);
      check_val("t5_frag0", {frag_valid, frag_lane}, {1'b1, 2'd0});
      step();
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      check_val("t5_async", {frag_valid, busy, frag_last}, {1'b0, 1'b0, 1'b0});
      q.delete();
      @(posedge clk);
      #1 reset = 1'b1;
      step();
      mon_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("t5_no_residual", {frag_valid, busy, req_ready}, {1'b0, 1'b0, 1'b1});
         step();
      end

      // 6: randomized traffic
      target = n_acc + NREQ;
      cyc    = 0;
      while (n_acc < target && cyc < 60000) begin
         rand_data();
         req_mask   = NL'($urandom);
         req_valid  = ($urandom_range(0, 3) != 0);
         frag_ready = ($urandom_range(0, 3) != 0);
         step();
         cyc++;
      end
      check_val("t6_budget", (cyc < 60000), 1'b1);
      req_valid  = 1'b0;
      frag_ready = 1'b1;
      repeat (8) step();
      check_val("t6_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
